regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the decode-stage register file for the pipelined MIPS core.
- N read ports and one write-back port; register 0 optionally hardwired to zero.
- Per-register pending-write scoreboard that reports RAW hazards to the stall logic.
- After reset, a sequential clear sweep writes zero to every register, one per cycle, so the array can map to RAM.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W.
- NUM_RD, 2, number of read ports.
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never scoreboarded.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k is bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy  out  NUM_RD  port k source has a pending write.
- iss_valid  in  1  an instruction issuing this cycle reserves iss_dst.
- iss_dst  in  ADDR_W  destination register to reserve.
- wb_valid  in  1  write-back strobe.
- wb_addr  in  ADDR_W  write-back register.
- wb_data  in  DATA_W  write-back data.
- ready  out  1  clear sweep finished; block is accepting traffic.
- pend_cnt  out  ADDR_W+1  number of registers currently scoreboarded.
- sb_err  out  1  sticky: write-back arrived for a register that was not pending.

Behaviour:
- State machine has two states, CLEAR and RUN.
- Reset:
  - RST_N low at a clock edge forces the state to CLEAR and clr_ptr to 0.
  - It also sets every scoreboard bit to 0, pend_cnt to 0, sb_err to 0 and ready to 0.
  - Reset asserted mid-sweep restarts the sweep at 0.
- CLEAR:
  - Each cycle writes 0 to reg[clr_ptr] and increments clr_ptr.
  - The cycle after the write of DEPTH-1, the state moves to RUN and ready goes to 1.
  - Latency: ready rises DEPTH edges after the first edge with RST_N high.
- In CLEAR:
  - iss_valid and wb_valid are ignored; no writes and no scoreboard change.
  - rd_busy is all ones and rd_data is don't-care.
- Reads in RUN:
  - rd_data[k] = reg[rd_addr[k]], asynchronous.
  - If ZERO_REG=1 and rd_addr[k]=0, rd_data[k] is 0.
- Writes: wb_valid in RUN writes wb_data to reg[wb_addr] at the edge. Writes to address 0 are dropped when ZERO_REG=1.
- Scoreboard:
  - iss_valid in RUN with a non-zero iss_dst sets sb[iss_dst]; address 0 is also settable when ZERO_REG=0.
  - wb_valid in RUN clears sb[wb_addr].
  - Issue and write-back to the same address in the same cycle: set wins, the bit stays 1, and the data is still written.
  - Issue to an already-set bit leaves it set and pend_cnt unchanged.
- pend_cnt:
  - +1 when a clear bit becomes set; -1 when a set bit becomes clear; net 0 when both happen on different addresses.
  - Never wraps; maximum is DEPTH.
- sb_err: set when wb_valid is in RUN, the target address is scoreboardable and its sb bit is 0. Cleared only by reset. The write is still performed.
- rd_busy[k] = sb[rd_addr[k]], except as modified by the optional feature.
- No other outputs change on reset release until ready.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-to-read forwarding):
  - When wb_valid is in RUN and wb_addr equals rd_addr[k] (and is not the zero register), rd_data[k] = wb_data in the same cycle.
  - rd_busy[k] is 0 for that cycle, unless iss_dst equals the same address with iss_valid asserted.
- Undefined:
  - rd_data shows the old value until the edge after write-back.
  - rd_busy[k] stays 1 through the write-back cycle and drops the next cycle.

Test Plan:
- Clear sweep: hold RST_N low for 2 cycles, then release. Required: ready=0 for exactly 32 edges (default params), then ready=1, every register reads 0, pend_cnt=0.
- Reset mid-sweep: pull RST_N low at clr_ptr=10, release. Required: ready rises 32 edges after release; a register preloaded before the sweep (e.g. r20=0xDEAD_BEEF) reads 0.
- RAW hazard:
  - Issue dst=5, then hold rd_addr[0]=5. Required: rd_busy[0]=1 and pend_cnt=1.
  - Write back r5=0x1234_5678. Required: busy drops the same cycle with bypass (rd_data=0x1234_5678), or the next cycle without it. pend_cnt returns to 0.
- Zero register: issue dst=0, then write back r0=0xFFFF_FFFF. Required: rd_data for address 0 is 0, rd_busy=0, pend_cnt=0, sb_err=0.
- Simultaneous events:
  - Same address: issue dst=7 while write-back to r7 (pending). Required: sb[7] stays 1, pend_cnt unchanged, reg7 updated.
  - Different addresses: issue dst=3 plus write-back to r9 (pending). Required: pend_cnt unchanged.
- Spurious write-back: write back r12 with no prior issue. Required: sb_err=1 from the next edge and remains 1; reg12 updated; pend_cnt stays 0.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, issue reservation, write-back and status.
// master drives addresses/strobes (pipeline side), slave is the register file.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_dst;
  logic                     wb_valid;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     ready;
  logic [ADDR_W:0]          pend_cnt;
  logic                     sb_err;

  modport master (
    output rd_addr, iss_valid, iss_dst, wb_valid, wb_addr, wb_data,
    input  rd_data, rd_busy, ready, pend_cnt, sb_err
  );

  modport slave (
    input  rd_addr, iss_valid, iss_dst, wb_valid, wb_addr, wb_data,
    output rd_data, rd_busy, ready, pend_cnt, sb_err
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read register file with pending-write scoreboard and post-reset clear sweep.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
//
// state | meaning
// CLEAR | sweep writes 0 to reg[clr_ptr], traffic ignored, all ports busy
// RUN   | normal read / issue / write-back operation, ready=1
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  regfile_sb_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  logic              run;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DEPTH-1:0]  sb;
  logic [CNT_W-1:0]  pend_cnt;
  logic              sb_err;
  logic              iss_set, wb_act, cnt_inc, cnt_dec;

  logic [DATA_W-1:0] rdat  [NUM_RD];
  logic              rbusy [NUM_RD];

  // Register 0 is excluded from storage and scoreboard when hardwired to zero.
  function automatic logic sbable(input logic [ADDR_W-1:0] a);
    return (ZERO_REG == 0) || (a != '0);
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + ADDR_W'(1);
        if (clr_ptr == '1) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  assign run     = (state == RUN);
  assign iss_set = run && bus.iss_valid && sbable(bus.iss_dst);
  assign wb_act  = run && bus.wb_valid && sbable(bus.wb_addr);

  // Single write port shared by the clear sweep and write-back keeps the array RAM-mappable.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.wb_addr;
    mem_wdata = bus.wb_data;
    if (RST_N) begin
      if (!run) begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr;
        mem_wdata = '0;
      end else if (wb_act) begin
        mem_we    = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) regs[mem_waddr] <= mem_wdata;
  end

  // A same-address issue keeps the bit set, so neither count direction applies.
  assign cnt_inc = iss_set && !sb[bus.iss_dst];
  assign cnt_dec = wb_act && sb[bus.wb_addr] && !(iss_set && (bus.iss_dst == bus.wb_addr));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sb       <= '0;
      pend_cnt <= '0;
      sb_err   <= 1'b0;
    end else begin
      if (wb_act) sb[bus.wb_addr] <= 1'b0;
      if (iss_set) sb[bus.iss_dst] <= 1'b1;
      pend_cnt <= pend_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
      if (wb_act && !sb[bus.wb_addr]) sb_err <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zero_hit;
    assign ra       = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign zero_hit = (ZERO_REG != 0) && (ra == '0);
`ifdef REGFILE_BYPASS_EN
    logic fwd;
    assign fwd      = wb_act && (bus.wb_addr == ra);
    assign rdat[k]  = zero_hit ? '0 : (fwd ? bus.wb_data : regs[ra]);
    assign rbusy[k] = !run ? 1'b1 : (fwd ? (iss_set && (bus.iss_dst == ra)) : sb[ra]);
`else
    assign rdat[k]  = zero_hit ? '0 : regs[ra];
    assign rbusy[k] = !run ? 1'b1 : sb[ra];
`endif
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      bus.rd_data[k*DATA_W +: DATA_W] = rdat[k];
      bus.rd_busy[k]                  = rbusy[k];
    end
  end

  assign bus.ready    = run;
  assign bus.pend_cnt = pend_cnt;
  assign bus.sb_err   = sb_err;
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed sequences plus randomized traffic
// compared against a behavioural model (register array + pending set).
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic CLK;
  logic RST_N;
  int   checks;
  int   errors;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [DW-1:0]    m_regs [DEPTH];
  logic [DEPTH-1:0] m_pend;
  bit               m_err;
  bit               m_run;
  bit               m_valid;
  int               m_edges;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wb_valid && bus.wb_addr == a) return bus.wb_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (!m_run) return 1'b1;
`ifdef REGFILE_BYPASS_EN
    if (bus.wb_valid && bus.wb_addr == a && a != 0)
      return bus.iss_valid && bus.iss_dst == a;
`endif
    return m_pend[a];
  endfunction

  task automatic model_edge();
    if (!RST_N) begin
      m_valid = 1; m_run = 0; m_edges = 0; m_pend = '0; m_err = 0;
    end else if (m_valid) begin
      if (!m_run) begin
        m_edges++;
        if (m_edges == DEPTH) begin
          m_run = 1;
          foreach (m_regs[i]) m_regs[i] = '0;
        end
      end else begin
        if (bus.wb_valid && bus.wb_addr != 0) begin
          if (!m_pend[bus.wb_addr]) m_err = 1;
          m_pend[bus.wb_addr] = 1'b0;
          m_regs[bus.wb_addr] = bus.wb_data;
        end
        if (bus.iss_valid && bus.iss_dst != 0) m_pend[bus.iss_dst] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [AW-1:0] ra;
    if (!m_valid) return;
    check("ready", bus.ready, m_run);
    check("pend_cnt", bus.pend_cnt, $countones(m_pend));
    check("sb_err", bus.sb_err, m_err);
    for (int p = 0; p < NR; p++) begin
      ra = bus.rd_addr[p*AW +: AW];
      check($sformatf("rd_busy%0d a=%0d", p, ra), bus.rd_busy[p], exp_busy(ra));
      if (m_run) check($sformatf("rd_data%0d a=%0d", p, ra), bus.rd_data[p*DW +: DW], exp_data(ra));
    end
  endtask

  // Inputs are set by the caller; outputs are compared mid-cycle, then the edge is taken.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 0; bus.iss_dst = '0;
    bus.wb_valid  = 0; bus.wb_addr = '0; bus.wb_data = '0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    bus.rd_addr[p*AW +: AW] = a;
  endtask

  task automatic wait_ready(input string tag, input int want);
    int n;
    n = 0;
    while (!bus.ready && n < 100) begin
      cycle();
      n++;
    end
    check(tag, n, want);
  endtask

  task automatic issue(input logic [AW-1:0] d);
    idle(); bus.iss_valid = 1; bus.iss_dst = d; cycle(); idle();
  endtask

  task automatic wback(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle(); bus.wb_valid = 1; bus.wb_addr = a; bus.wb_data = d; cycle(); idle();
  endtask

  initial begin
    int start;
    int idx;
    checks = 0; errors = 0;
    m_valid = 0; m_run = 0; m_edges = 0; m_pend = '0; m_err = 0;
    foreach (m_regs[i]) m_regs[i] = '0;
    bus.rd_addr = '0;
    idle();
    RST_N = 0;
    @(negedge CLK);

    // Clear sweep after a 2-cycle reset
    cycle(); cycle();
    check("rst_ready", bus.ready, 1'b0);
    check("rst_pend", bus.pend_cnt, 0);
    RST_N = 1;
    wait_ready("sweep_len", DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(0, AW'(i)); set_rd(1, AW'(DEPTH-1-i));
      cycle();
    end

    // Preload r20, then reset in the middle of the sweep
    issue(5'd20);
    wback(5'd20, 32'hDEAD_BEEF);
    set_rd(0, 5'd20); #1;
    check("preload_r20", bus.rd_data[DW-1:0], 32'hDEAD_BEEF);
    RST_N = 0; cycle(); RST_N = 1;
    for (int i = 0; i < 10; i++) cycle();
    RST_N = 0; cycle(); RST_N = 1;
    wait_ready("midsweep_len", DEPTH);
    set_rd(0, 5'd20); #1;
    check("r20_cleared", bus.rd_data[DW-1:0], 32'h0);
    cycle();

    // RAW hazard on r5
    issue(5'd5);
    set_rd(0, 5'd5); #1;
    check("raw_busy", bus.rd_busy[0], 1'b1);
    check("raw_pend", bus.pend_cnt, 1);
    bus.wb_valid = 1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234_5678; #1;
`ifdef REGFILE_BYPASS_EN
    check("raw_wb_busy", bus.rd_busy[0], 1'b0);
    check("raw_wb_fwd", bus.rd_data[DW-1:0], 32'h1234_5678);
`else
    check("raw_wb_busy", bus.rd_busy[0], 1'b1);
`endif
    cycle(); idle(); #1;
    check("raw_after_busy", bus.rd_busy[0], 1'b0);
    check("raw_after_data", bus.rd_data[DW-1:0], 32'h1234_5678);
    check("raw_after_pend", bus.pend_cnt, 0);
    cycle();

    // Zero register is never scoreboarded or written
    issue(5'd0);
    wback(5'd0, 32'hFFFF_FFFF);
    set_rd(0, 5'd0); #1;
    check("zero_data", bus.rd_data[DW-1:0], 32'h0);
    check("zero_busy", bus.rd_busy[0], 1'b0);
    check("zero_pend", bus.pend_cnt, 0);
    check("zero_err", bus.sb_err, 1'b0);
    cycle();

    // Same-address issue + write-back: set wins, data written
    issue(5'd7);
    bus.iss_valid = 1; bus.iss_dst = 5'd7;
    bus.wb_valid = 1; bus.wb_addr = 5'd7; bus.wb_data = 32'hA5A5_0707;
    cycle(); idle();
    set_rd(0, 5'd7); #1;
    check("same_busy", bus.rd_busy[0], 1'b1);
    check("same_pend", bus.pend_cnt, 1);
    check("same_data", bus.rd_data[DW-1:0], 32'hA5A5_0707);
    wback(5'd7, 32'h0000_0777);

    // Different addresses: net zero
    issue(5'd9);
    bus.iss_valid = 1; bus.iss_dst = 5'd3;
    bus.wb_valid = 1; bus.wb_addr = 5'd9; bus.wb_data = 32'h0909_0909;
    cycle(); idle(); #1;
    check("diff_pend", bus.pend_cnt, 1);
    wback(5'd3, 32'h0303_0303);

    // Randomized traffic; write-backs target pending registers (or r0)
    for (int c = 0; c < 400; c++) begin
      idle();
      bus.iss_valid = 1'($urandom_range(1));
      bus.iss_dst   = AW'($urandom_range(7));
      if (m_pend != 0 && $urandom_range(2) != 0) begin
        start = $urandom_range(DEPTH-1);
        for (int j = 0; j < DEPTH; j++) begin
          idx = (start + j) % DEPTH;
          if (m_pend[idx] && !bus.wb_valid) begin
            bus.wb_valid = 1; bus.wb_addr = AW'(idx);
          end
        end
        bus.wb_data = $urandom;
      end else if ($urandom_range(9) == 0) begin
        bus.wb_valid = 1; bus.wb_addr = '0; bus.wb_data = $urandom;
      end
      set_rd(0, ($urandom_range(1) != 0) ? bus.wb_addr : AW'($urandom_range(7)));
      set_rd(1, AW'($urandom_range(DEPTH-1)));
      cycle();
    end
    idle();

    // Drain, then a spurious write-back to r12
    for (int i = 0; i < DEPTH; i++)
      if (m_pend[i]) wback(AW'(i), $urandom);
    set_rd(0, 5'd12);
    bus.wb_valid = 1; bus.wb_addr = 5'd12; bus.wb_data = 32'hC0DE_0012; #1;
    check("spur_err_pre", bus.sb_err, 1'b0);
    cycle(); idle(); #1;
    check("spur_err", bus.sb_err, 1'b1);
    check("spur_data", bus.rd_data[DW-1:0], 32'hC0DE_0012);
    check("spur_pend", bus.pend_cnt, 0);
    cycle(); cycle(); #1;
    check("spur_err_sticky", bus.sb_err, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
